// File: rtl/sobel_frame_controller.sv
//-----------------------------------------------------------------------------
// sobel_frame_controller
//
// Per-frame sequencer for the grayscale/Sobel edge pipeline. Sits between the
// CCD capture/decimation stage and the image-processing datapath / VGA mux.
//   - Tracks the X/Y position of each decimated pixel and flags the border
//     region where the 3x3 window is not yet filled.
//   - Latches host mode/threshold requests into pending registers and only
//     promotes them to the active registers at start-of-frame, so a frame
//     never mixes settings.
//   - Emits start/end-of-frame and end-of-line pulses and a sticky overrun
//     error.
//
// Optional feature macro: FRAME_CNT_EN
//   defined   : oFRAME_CNT counts completed frames (wraps at 16'hFFFF)
//   undefined : oFRAME_CNT is tied to zero and the counter is removed
//
// Ports:
//   iCLK         in   1   pipeline clock
//   iRST         in   1   asynchronous active-low reset
//   iFVAL        in   1   frame valid from the capture stage
//   iDVAL        in   1   decimated pixel valid
//   iMODE_REQ    in   2   requested mode: 0 raw, 1 gray, 2 Sobel-X, 3 Sobel-Y
//   iTHRESH_REQ  in   12  requested edge threshold
//   iCFG_STB     in   1   one-cycle strobe capturing the two requests above
//   oMODE        out  2   mode active for the current frame
//   oTHRESH      out  12  threshold active for the current frame
//   oX / oY      out  11  column / row of the pixel presented this cycle
//   oBORDER      out  1   pixel lies in the masked top/left border
//   oSOF         out  1   one-cycle pulse at frame start
//   oEOL         out  1   one-cycle pulse the cycle after a line's last pixel
//   oEOF         out  1   one-cycle pulse at frame end
//   oCFG_PEND    out  1   a captured request is waiting for the next frame
//   oERR         out  1   sticky overrun flag (cleared only by reset)
//   oFRAME_CNT   out  16  completed-frame counter
//-----------------------------------------------------------------------------
module sobel_frame_controller #(
   parameter int H_ACTIVE = 320,  // valid pixels per line after decimation
   parameter int V_ACTIVE = 240,  // valid lines per frame after decimation
   parameter int BORDER   = 2     // masked rows/cols (3x3 window fill latency)
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iFVAL,
   input  logic        iDVAL,
   input  logic [1:0]  iMODE_REQ,
   input  logic [11:0] iTHRESH_REQ,
   input  logic        iCFG_STB,
   output logic [1:0]  oMODE,
   output logic [11:0] oTHRESH,
   output logic [10:0] oX,
   output logic [10:0] oY,
   output logic        oBORDER,
   output logic        oSOF,
   output logic        oEOL,
   output logic        oEOF,
   output logic        oCFG_PEND,
   output logic        oERR,
   output logic [15:0] oFRAME_CNT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_DRAIN
   } state_t;

   localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
   localparam logic [10:0] BORDER_W = 11'(BORDER);

   state_t      state, state_nxt;
   logic        fval_q;
   logic        fval_rise, fval_fall;
   logic        sof_hold;
   logic        start_frame, end_frame, pixel, hold_set;
   logic        line_done;
   logic [10:0] x_q, y_q;
   logic        y_full;       // last legal line completed; more pixels overrun
   logic [1:0]  mode_pend;
   logic [11:0] thresh_pend;

   assign fval_rise = iFVAL & ~fval_q;
   assign fval_fall = ~iFVAL & fval_q;

   //--------------------------------------------------------------------------
   // FSM state register
   //--------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of always-block ordering.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) state <= S_IDLE;
      else       state <= state_nxt;
   end

   //--------------------------------------------------------------------------
   // FSM next-state and control decode
   //--------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      pixel       = 1'b0;
      hold_set    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (fval_rise || sof_hold) begin
               start_frame = 1'b1;
               state_nxt   = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            pixel = iDVAL;
            if (fval_fall) begin
               end_frame = 1'b1;
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // A rise here is remembered and consumed by IDLE next cycle.
            hold_set  = fval_rise;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign line_done = pixel && (x_q == X_LAST);

   //--------------------------------------------------------------------------
   // Frame-valid edge detection and held start request
   //--------------------------------------------------------------------------
   // fval_q resets high: if reset releases in the middle of a frame, the
   // still-high iFVAL must not look like a rise; the next real rise starts
   // the next frame.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         fval_q   <= 1'b1;
         sof_hold <= 1'b0;
      end else begin
         fval_q <= iFVAL;
         if (start_frame)   sof_hold <= 1'b0;
         else if (hold_set) sof_hold <= 1'b1;
      end
   end

   //--------------------------------------------------------------------------
   // Pixel position and overrun detection
   //--------------------------------------------------------------------------
   // X wraps exactly at H_ACTIVE. Y saturates on the last legal line; a pixel
   // arriving after that line has completed is the overrun that sets oERR.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         x_q    <= '0;
         y_q    <= '0;
         y_full <= 1'b0;
         oERR   <= 1'b0;
      end else if (start_frame) begin
         x_q    <= '0;
         y_q    <= '0;
         y_full <= 1'b0;
      end else if (pixel) begin
         if (y_full) oERR <= 1'b1;
         if (line_done) begin
            x_q <= '0;
            if (y_q == Y_LAST) y_full <= 1'b1;
            else               y_q    <= y_q + 11'd1;
         end else begin
            x_q <= x_q + 11'd1;
         end
      end
   end

   assign oX      = x_q;
   assign oY      = y_q;
   assign oBORDER = (x_q < BORDER_W) || (y_q < BORDER_W);

   //--------------------------------------------------------------------------
   // Frame / line pulses
   //--------------------------------------------------------------------------
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oSOF <= 1'b0;
         oEOF <= 1'b0;
         oEOL <= 1'b0;
      end else begin
         oSOF <= start_frame;
         oEOF <= end_frame;
         oEOL <= line_done;
      end
   end

   //--------------------------------------------------------------------------
   // Configuration: pending capture and start-of-frame promotion
   //--------------------------------------------------------------------------
   // A strobe coinciding with the start of frame goes straight to the active
   // registers; it also refreshes the pending copy so a later frame without a
   // new strobe keeps the same settings.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         mode_pend   <= '0;
         thresh_pend <= '0;
         oMODE       <= '0;
         oTHRESH     <= '0;
         oCFG_PEND   <= 1'b0;
      end else begin
         if (iCFG_STB) begin
            mode_pend   <= iMODE_REQ;
            thresh_pend <= iTHRESH_REQ;
         end
         if (start_frame) begin
            oMODE     <= iCFG_STB ? iMODE_REQ   : mode_pend;
            oTHRESH   <= iCFG_STB ? iTHRESH_REQ : thresh_pend;
            oCFG_PEND <= 1'b0;
         end else if (iCFG_STB) begin
            oCFG_PEND <= 1'b1;
         end
      end
   end

   //--------------------------------------------------------------------------
   // Completed-frame counter
   //--------------------------------------------------------------------------
`ifdef FRAME_CNT_EN
   logic [15:0] frame_cnt;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST)                frame_cnt <= '0;
      else if (state == S_DRAIN) frame_cnt <= frame_cnt + 16'd1;
   end

   assign oFRAME_CNT = frame_cnt;
`else
   assign oFRAME_CNT = '0;
`endif

endmodule

// File: tb/tb_sobel_frame_controller.sv
//-----------------------------------------------------------------------------
// tb_sobel_frame_controller
//
// Self-checking bench for sobel_frame_controller. The line length is reduced
// to keep frames short; the frame height keeps its full 240 lines.
//-----------------------------------------------------------------------------
module tb_sobel_frame_controller;

   localparam int H = 16;
   localparam int V = 240;
   localparam int B = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        fval_i, dval_i, stb_i;
   logic [1:0]  mode_i;
   logic [11:0] thr_i;
   logic [1:0]  mode_o;
   logic [11:0] thr_o;
   logic [10:0] x_o, y_o;
   logic        border_o, sof_o, eol_o, eof_o, pend_o, err_o;
   logic [15:0] fcnt_o;

   int checks   = 0;
   int failures = 0;
   int sof_cnt  = 0;
   int eol_cnt  = 0;
   int eof_cnt  = 0;

   // Reference model state
   logic [1:0]  m_mode, m_pmode;
   logic [11:0] m_thr, m_pthr;
   bit          m_pend, m_err;
   int          m_frames;
   int          n;           // pixels accepted in the current frame

   typedef struct {
      logic        fval, dval, stb;
      logic [1:0]  mode;
      logic [11:0] thr;
      logic        e_sof, e_eof, e_eol, e_pend;
      logic [1:0]  e_mode;
      logic [11:0] e_thr;
      logic [10:0] e_x, e_y;
      logic        e_brd;
   } vec_t;

   vec_t tbl [10];

   always #5 clk = ~clk;

   sobel_frame_controller #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .BORDER   (B)
   ) dut (
      .iCLK        (clk),
      .iRST        (rst),
      .iFVAL       (fval_i),
      .iDVAL       (dval_i),
      .iMODE_REQ   (mode_i),
      .iTHRESH_REQ (thr_i),
      .iCFG_STB    (stb_i),
      .oMODE       (mode_o),
      .oTHRESH     (thr_o),
      .oX          (x_o),
      .oY          (y_o),
      .oBORDER     (border_o),
      .oSOF        (sof_o),
      .oEOL        (eol_o),
      .oEOF        (eof_o),
      .oCFG_PEND   (pend_o),
      .oERR        (err_o),
      .oFRAME_CNT  (fcnt_o)
   );

   // Pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (sof_o === 1'b1) sof_cnt++;
      if (eol_o === 1'b1) eol_cnt++;
      if (eof_o === 1'b1) eof_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_fcnt();
`ifdef FRAME_CNT_EN
      return 16'(m_frames);
`else
      return 16'd0;
`endif
   endfunction

   task automatic model_reset();
      m_mode = '0; m_pmode = '0; m_thr = '0; m_pthr = '0;
      m_pend = 1'b0; m_err = 1'b0; m_frames = 0; n = 0;
   endtask

   // Raise iFVAL (optionally with a coincident strobe) and check the start.
   task automatic start_frame(input bit stb, input logic [1:0] m, input logic [11:0] t);
      fval_i = 1'b1; dval_i = 1'b0;
      stb_i = stb; mode_i = m; thr_i = t;
      step();
      stb_i = 1'b0;
      if (stb) begin
         m_pmode = m; m_pthr = t;
      end
      m_mode = m_pmode; m_thr = m_pthr; m_pend = 1'b0; n = 0;
      check("sof pulse", sof_o, 1);
      check("sof mode", mode_o, m_mode);
      check("sof thresh", thr_o, m_thr);
      check("sof cfg_pend", pend_o, m_pend);
      check("sof x", x_o, 0);
      check("sof y", y_o, 0);
   endtask

   // Feed npix pixels with random gaps; optional strobe at pixel stb_pix.
   // Every pixel's coordinates/border and every cycle's sticky/config
   // outputs are compared with the model; mismatches are tallied in bad.
   task automatic feed(input int npix, input int gap_max, input int stb_pix,
                       input logic [1:0] sm, input logic [11:0] st,
                       output int bad, output int masked,
                       output logic [10:0] lx, output logic [10:0] ly);
      int sent;
      bit stb_done;
      bit d;
      int ex, ey;
      sent = 0; stb_done = 1'b0; bad = 0; masked = 0; lx = '0; ly = '0;
      while (sent < npix) begin
         d = (gap_max == 0) || ($urandom_range(gap_max) == 0);
         dval_i = d;
         if (!stb_done && stb_pix >= 0 && sent == stb_pix) begin
            stb_i = 1'b1; mode_i = sm; thr_i = st; stb_done = 1'b1;
            m_pmode = sm; m_pthr = st; m_pend = 1'b1;
         end
         if (d) begin
            ex = n % H;
            ey = (n / H >= V) ? V - 1 : n / H;
            if (x_o !== 11'(ex) || y_o !== 11'(ey) || border_o !== (ex < B || ey < B))
               bad++;
            if (border_o === 1'b1) masked++;
            lx = x_o; ly = y_o;
         end
         step();
         stb_i = 1'b0;
         if (d) begin
            if (n / H >= V) m_err = 1'b1;
            n++; sent++;
         end
         if (err_o !== m_err || mode_o !== m_mode || thr_o !== m_thr || pend_o !== m_pend)
            bad++;
      end
      dval_i = 1'b0;
   endtask

   task automatic end_frame();
      fval_i = 1'b0; dval_i = 1'b0;
      step();
      check("eof pulse", eof_o, 1);
      step();
      step();
      m_frames++;
   endtask

   task automatic run_frame(input int npix, input int gap_max, input int stb_pix,
                            input logic [1:0] sm, input logic [11:0] st, input bit full,
                            output logic [10:0] lx, output logic [10:0] ly);
      int s0, e0, l0, bad, masked;
      s0 = sof_cnt; e0 = eof_cnt; l0 = eol_cnt;
      start_frame(1'b0, 2'd0, 12'd0);
      feed(npix, gap_max, stb_pix, sm, st, bad, masked, lx, ly);
      end_frame();
      check("frame pixel mismatches", bad, 0);
      check("frame sof count", sof_cnt - s0, 1);
      check("frame eof count", eof_cnt - e0, 1);
      check("frame eol count", eol_cnt - l0, npix / H);
      check("frame err", err_o, m_err);
      check("frame cfg_pend", pend_o, m_pend);
      check("frame counter", fcnt_o, exp_fcnt());
      if (full) begin
         check("full masked px", masked, B * H + B * (V - B));
         check("full last x", lx, H - 1);
         check("full last y", ly, V - 1);
      end
   endtask

   initial begin
      logic [10:0] lx, ly;
      int bad, masked, s0, npix, stb_pix;

      // Configuration sequence vectors (applied from reset, one row per cycle)
      tbl[0] = '{1'b0,1'b0,1'b1,2'd2,12'h100, 1'b0,1'b0,1'b0,1'b1, 2'd0,12'h000, 11'd0,11'd0,1'b1};
      tbl[1] = '{1'b1,1'b0,1'b0,2'd0,12'h000, 1'b1,1'b0,1'b0,1'b0, 2'd2,12'h100, 11'd0,11'd0,1'b1};
      tbl[2] = '{1'b1,1'b1,1'b0,2'd0,12'h000, 1'b0,1'b0,1'b0,1'b0, 2'd2,12'h100, 11'd1,11'd0,1'b1};
      tbl[3] = '{1'b1,1'b1,1'b1,2'd3,12'h7FF, 1'b0,1'b0,1'b0,1'b1, 2'd2,12'h100, 11'd2,11'd0,1'b1};
      tbl[4] = '{1'b0,1'b0,1'b0,2'd0,12'h000, 1'b0,1'b1,1'b0,1'b1, 2'd2,12'h100, 11'd2,11'd0,1'b1};
      tbl[5] = '{1'b0,1'b0,1'b0,2'd0,12'h000, 1'b0,1'b0,1'b0,1'b1, 2'd2,12'h100, 11'd2,11'd0,1'b1};
      tbl[6] = '{1'b1,1'b0,1'b1,2'd1,12'h0AB, 1'b1,1'b0,1'b0,1'b0, 2'd1,12'h0AB, 11'd0,11'd0,1'b1};
      tbl[7] = '{1'b1,1'b1,1'b0,2'd0,12'h000, 1'b0,1'b0,1'b0,1'b0, 2'd1,12'h0AB, 11'd1,11'd0,1'b1};
      tbl[8] = '{1'b0,1'b0,1'b0,2'd0,12'h000, 1'b0,1'b1,1'b0,1'b0, 2'd1,12'h0AB, 11'd1,11'd0,1'b1};
      tbl[9] = '{1'b0,1'b0,1'b0,2'd0,12'h000, 1'b0,1'b0,1'b0,1'b0, 2'd1,12'h0AB, 11'd1,11'd0,1'b1};

      rst = 1'b0; fval_i = 1'b0; dval_i = 1'b0; stb_i = 1'b0;
      mode_i = '0; thr_i = '0;
      model_reset();

      // Reset state
      repeat (2) step();
      check("reset mode", mode_o, 0);
      check("reset thresh", thr_o, 0);
      check("reset x", x_o, 0);
      check("reset y", y_o, 0);
      check("reset pulses", {sof_o, eol_o, eof_o}, 0);
      check("reset cfg_pend", pend_o, 0);
      check("reset err", err_o, 0);
      check("reset frame cnt", fcnt_o, 0);
      rst = 1'b1;
      step();

      // Table: pending config, mid-frame strobe, short frames, SOF bypass
      for (int i = 0; i < 10; i++) begin
         fval_i = tbl[i].fval; dval_i = tbl[i].dval; stb_i = tbl[i].stb;
         mode_i = tbl[i].mode; thr_i = tbl[i].thr;
         step();
         check($sformatf("vec%0d sof", i), sof_o, tbl[i].e_sof);
         check($sformatf("vec%0d eof", i), eof_o, tbl[i].e_eof);
         check($sformatf("vec%0d eol", i), eol_o, tbl[i].e_eol);
         check($sformatf("vec%0d cfg_pend", i), pend_o, tbl[i].e_pend);
         check($sformatf("vec%0d mode", i), mode_o, tbl[i].e_mode);
         check($sformatf("vec%0d thresh", i), thr_o, tbl[i].e_thr);
         check($sformatf("vec%0d x", i), x_o, tbl[i].e_x);
         check($sformatf("vec%0d y", i), y_o, tbl[i].e_y);
         check($sformatf("vec%0d border", i), border_o, tbl[i].e_brd);
      end
      stb_i = 1'b0; fval_i = 1'b0; dval_i = 1'b0;
      m_mode = 2'd1; m_thr = 12'h0AB; m_pmode = 2'd1; m_pthr = 12'h0AB;
      m_pend = 1'b0; m_err = 1'b0; m_frames = 2;
      step();
      check("table frame cnt", fcnt_o, exp_fcnt());

      // Full frame, no gaps, mid-frame request mode=2 thresh=0x100
      run_frame(H * V, 0, H * V / 2, 2'd2, 12'h100, 1'b1, lx, ly);
      // Full frame with gaps; picks up the request at its start
      run_frame(H * V, 2, -1, 2'd0, 12'd0, 1'b1, lx, ly);

      // iFVAL rise during DRAIN is held and taken one cycle later
      start_frame(1'b0, 2'd0, 12'd0);
      feed(H + 3, 0, -1, 2'd0, 12'd0, bad, masked, lx, ly);
      check("held pre pixels", bad, 0);
      fval_i = 1'b0;
      step();
      check("held eof", eof_o, 1);
      fval_i = 1'b1;
      step();
      check("held no sof in drain", sof_o, 0);
      step();
      check("held sof after drain", sof_o, 1);
      m_frames++; n = 0; m_mode = m_pmode; m_thr = m_pthr; m_pend = 1'b0;
      check("held x", x_o, 0);
      check("held y", y_o, 0);
      check("held frame cnt", fcnt_o, exp_fcnt());
      feed(2 * H + 1, 1, -1, 2'd0, 12'd0, bad, masked, lx, ly);
      check("held post pixels", bad, 0);
      end_frame();

      // Random short frames with random mid-frame requests
      for (int f = 0; f < 4; f++) begin
         npix    = int'($urandom_range(H * V - 1, 1));
         stb_pix = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(npix - 1));
         run_frame(npix, int'($urandom_range(3)), stb_pix,
                   2'($urandom_range(3)), 12'($urandom_range(4095)), 1'b0, lx, ly);
      end

      // Overrun: one line too many
      run_frame(H * (V + 1), 0, -1, 2'd0, 12'd0, 1'b0, lx, ly);
      check("overrun err", err_o, 1);
      check("overrun y holds", ly, V - 1);
      // Error is sticky across frames
      run_frame(H * 2 + 3, 1, -1, 2'd0, 12'd0, 1'b0, lx, ly);
      check("err sticky", err_o, 1);

      // Asynchronous reset in the middle of a frame
      start_frame(1'b0, 2'd0, 12'd0);
      feed(H * 3 + 4, 0, 1, 2'd3, 12'h555, bad, masked, lx, ly);
      rst = 1'b0;
      #1;
      check("midrst mode", mode_o, 0);
      check("midrst thresh", thr_o, 0);
      check("midrst x", x_o, 0);
      check("midrst y", y_o, 0);
      check("midrst pulses", {sof_o, eol_o, eof_o}, 0);
      check("midrst cfg_pend", pend_o, 0);
      check("midrst err", err_o, 0);
      check("midrst frame cnt", fcnt_o, 0);
      model_reset();
      step();
      rst = 1'b1;
      s0 = sof_cnt;
      dval_i = 1'b1;
      repeat (4) step();
      check("post-reset dval ignored", x_o, 0);
      check("post-reset no sof", sof_cnt - s0, 0);
      fval_i = 1'b0; dval_i = 1'b0;
      repeat (3) step();
      run_frame(H * 3 + 5, 1, -1, 2'd0, 12'd0, 1'b0, lx, ly);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
